// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-counter FSM states and default address parameters.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int              XLEN_DEF         = 32;
  localparam logic [31:0]     RESET_VECTOR_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the fetch stage: trap, redirect (with alignment check),
// sequential advance, or hold.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int INC_BYTES = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  logic target_misaligned;

  // Compressed-capable builds only need halfword alignment.
  always_comb begin
    target_misaligned = 1'b0;
    if (INC_BYTES == 2) begin
      target_misaligned = redirect_pc[0];
    end else begin
      target_misaligned = |redirect_pc[1:0];
    end
  end

  always_comb begin
    next_pc  = pc;
    misalign = 1'b0;
    if (trap_valid) begin
      next_pc = trap_vector;
    end else if (redirect_valid) begin
      if (target_misaligned) begin
        next_pc  = trap_vector;
        misalign = 1'b1;
      end else begin
        next_pc = redirect_pc;
      end
    end else if (advance) begin
      next_pc = pc + XLEN'(INC_BYTES);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALTED control, registered PC with
// trap/redirect priority, misalignment pulse and accepted-fetch counter.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              INC_BYTES    = 4,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  pc_out,
  output logic             pc_valid,
  output logic             misalign_err,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  pc_state_e       state;
  pc_state_e       state_next;
  logic [XLEN-1:0] next_pc;
  logic            misalign_now;
  logic            accept;

  assign pc_valid = (state == RUN);
  assign halted   = (state == HALTED);
  assign accept   = pc_valid && fetch_ready;

  pc_next_sel #(
    .XLEN      (XLEN),
    .INC_BYTES (INC_BYTES)
  ) u_next_sel (
    .pc             (pc_out),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (accept),
    .next_pc        (next_pc),
    .misalign       (misalign_now)
  );

  // A trap or redirect in the same cycle as halt_req keeps us running so the
  // new PC is fetched at least once before halting.
  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:   state_next = RUN;
      RUN: begin
        if (halt_req && !trap_valid && !redirect_valid) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        if (resume) begin
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pc_out       <= RESET_VECTOR;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_next;
      pc_out       <= next_pc;
      misalign_err <= misalign_now;
      if (accept) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; a second instance with INC_BYTES=2
// shares the stimulus to cover compressed alignment.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic        fetch_ready;

  logic [31:0] pc_out,   pc_out2;
  logic        pc_valid, pc_valid2;
  logic        misalign_err, misalign_err2;
  logic        halted,   halted2;
  logic [31:0] fetch_count, fetch_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INC_BYTES(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .trap_valid(trap_valid), .trap_vector(trap_vector),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .resume(resume), .fetch_ready(fetch_ready), .pc_out(pc_out), .pc_valid(pc_valid),
    .misalign_err(misalign_err), .halted(halted), .fetch_count(fetch_count)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INC_BYTES(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .trap_valid(trap_valid), .trap_vector(trap_vector),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .resume(resume), .fetch_ready(fetch_ready), .pc_out(pc_out2), .pc_valid(pc_valid2),
    .misalign_err(misalign_err2), .halted(halted2), .fetch_count(fetch_count2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and leave the bench 1ns past the edge.
  task automatic applyStimulus(input logic rst, input logic tv, input logic [31:0] tvec,
                               input logic rv, input logic [31:0] rpc,
                               input logic hr, input logic res, input logic fr);
    reset          = rst;
    trap_valid     = tv;
    trap_vector    = tvec;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    resume         = res;
    fetch_ready    = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                            input logic valid, input logic hlt);
    checkOutput({tag, ".pc"},     pc_out,          pc);
    checkOutput({tag, ".count"},  fetch_count,     cnt);
    checkOutput({tag, ".valid"},  32'(pc_valid),   32'(valid));
    checkOutput({tag, ".halted"}, 32'(halted),     32'(hlt));
  endtask

  initial begin
    applyStimulus(1, 0, 32'h80, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h80, 0, 0, 0, 0, 0);
    checkState("reset", 32'h0, 0, 0, 0);
    checkOutput("reset.misalign", 32'(misalign_err), 0);

    // BOOT cycle: no fetch yet
    applyStimulus(0, 0, 32'h80, 0, 0, 0, 0, 1);
    checkState("boot", 32'h0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 32'h80, 0, 0, 0, 0, 1);
      checkState($sformatf("seq%0d", i), 32'(4 * i), 32'(i), 1, 0);
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h80, 0, 0, 0, 0, 0);
      checkState($sformatf("stall%0d", i), 32'h10, 4, 1, 0);
    end

    // Trap beats redirect; the handshake still counts
    applyStimulus(0, 1, 32'h80, 1, 32'h200, 0, 0, 1);
    checkState("trap_vs_redir", 32'h80, 5, 1, 0);

    applyStimulus(0, 0, 32'h80, 1, 32'h102, 0, 0, 0);
    checkOutput("misal.pc4", pc_out, 32'h80);
    checkOutput("misal.err4", 32'(misalign_err), 1);
    checkOutput("misal.pc2", pc_out2, 32'h102);
    checkOutput("misal.err2", 32'(misalign_err2), 0);
    applyStimulus(0, 0, 32'h80, 0, 0, 0, 0, 0);
    checkOutput("misal.pulse", 32'(misalign_err), 0);
    checkOutput("misal.hold", pc_out, 32'h80);
    applyStimulus(0, 0, 32'h80, 0, 0, 0, 0, 1);
    checkState("after_misal", 32'h84, 6, 1, 0);
    checkOutput("inc2.pc", pc_out2, 32'h104);

    applyStimulus(0, 0, 32'h80, 0, 0, 1, 0, 1);
    checkState("halt", 32'h88, 7, 0, 1);
    applyStimulus(0, 0, 32'h80, 0, 0, 1, 0, 1);
    checkState("halt.frozen", 32'h88, 7, 0, 1);
    applyStimulus(0, 1, 32'h40, 0, 0, 1, 0, 1);
    checkState("halt.trap", 32'h40, 7, 0, 1);
    // Resume wins over a held halt_req, then re-halts
    applyStimulus(0, 0, 32'h40, 0, 0, 1, 1, 1);
    checkState("resume_hr", 32'h40, 7, 1, 0);
    applyStimulus(0, 0, 32'h40, 0, 0, 1, 0, 1);
    checkState("rehalt", 32'h44, 8, 0, 1);
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 1, 1);
    checkState("resume", 32'h44, 8, 1, 0);
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 1);
    checkState("resume.fetch", 32'h48, 9, 1, 0);

    applyStimulus(0, 0, 32'h40, 1, 32'h300, 1, 0, 1);
    checkState("halt_redir", 32'h300, 10, 1, 0);

    applyStimulus(0, 0, 32'h40, 1, 32'hFFFF_FFFC, 0, 0, 0);
    checkState("wrap.setup", 32'hFFFF_FFFC, 10, 1, 0);
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 1);
    checkState("wrap", 32'h0, 11, 1, 0);
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 1);
    checkState("wrap.next", 32'h4, 12, 1, 0);
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 0);
    checkState("stall2", 32'h4, 12, 1, 0);
    applyStimulus(1, 1, 32'h40, 0, 0, 0, 0, 0);
    checkState("midreset", 32'h0, 0, 0, 0);
    checkOutput("midreset.misal", 32'(misalign_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got running, want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
